alu_seq_ctrl: RTL and testbench

Multi-byte operation sequencer that owns the 8-bit ALU and drives it over several cycles to perform NBYTES-wide add, left shift and right shift. It accepts one wide request over a valid/ready handshake, issues one ALU operation per cycle, and captures each result byte. It chains carries through the ALU's add/add-carry pair and shift spill through its shift/shift-overflow pair. It returns the wide result on a valid/ready response port and sits between the instruction decoder and the ALU.

---
 rtl/alu_seq_ctrl_pkg.sv | 28 ++
 rtl/alu_seq_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared ALU opcode and sequencer-operation encodings for the multi-byte ALU sequencer.
// Optional feature macro used by the sequencer: ALU_SEQ_PERF_EN.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_RSH  = 4'd1,
        ALU_LSH  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SEL  = 4'd5,
        ALU_NOT  = 4'd8,
        ALU_LNOT = 4'd9,
        ALU_SHO  = 4'd10,
        ALU_ADC  = 4'd11,
        ALU_EXIT = 4'd12,
        ALU_NOP  = 4'd13,
        ALU_JMP  = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        SEQ_ADD = 2'd0,
        SEQ_SHL = 2'd1,
        SEQ_SHR = 2'd2,
        SEQ_RSV = 2'd3
    } seq_op_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Drives the shared 8-bit ALU byte-by-byte to perform NBYTES-wide add / shift-left / shift-right.
// ALU_SEQ_PERF_EN adds a saturating perf_ops count of issued non-NOP ALU operations.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_data,
    output logic                  rsp_carry,
    output logic [7:0]            alu_op1,
    output logic [7:0]            alu_op2,
    output logic [3:0]            alu_operation,
    input  logic [7:0]            alu_result
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]           perf_ops
`endif
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD0,
        S_ADC,
        S_ADDH,
        S_SHF,
        S_SHO,
        S_DONE
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [8*NBYTES-1:0]    r_a;
    logic [8*NBYTES-1:0]    r_b;
    logic [8*NBYTES-1:0]    r_res;
    seq_op_e                r_op;
    logic [IW-1:0]          r_idx;
    logic [7:0]             r_t;
    logic                   r_cflag;

    logic [7:0]             w_a_byte;
    logic [7:0]             w_b_byte;
    logic [IW-1:0]          w_idx_nxt;
    logic                   w_last;
    alu_op_e                w_alu_op;
    logic                   w_byte_we;
    logic [7:0]             w_byte_dat;
    logic                   w_cflag_we;
    logic                   w_cflag_dat;
    logic                   w_idx_step;
    logic                   w_t_we;
    logic                   w_accept;

    assign w_a_byte  = r_a[{r_idx, 3'b000} +: 8];
    assign w_b_byte  = r_b[{r_idx, 3'b000} +: 8];
    // Right shifts walk from the top byte down so spill flows toward byte 0.
    assign w_idx_nxt = (r_op == SEQ_SHR) ? (r_idx - 1'b1) : (r_idx + 1'b1);
    assign w_last    = (r_op == SEQ_SHR) ? (r_idx == '0) : (r_idx == LAST_IDX);
    assign w_accept  = (r_state == S_IDLE) && req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_alu_op    = ALU_NOP;
        alu_op1     = 8'h00;
        alu_op2     = 8'h00;
        w_byte_we   = 1'b0;
        w_byte_dat  = alu_result;
        w_cflag_we  = 1'b0;
        w_cflag_dat = 1'b0;
        w_idx_step  = 1'b0;
        w_t_we      = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (seq_op_e'(req_op))
                        SEQ_ADD: w_state_nxt = S_ADD0;
                        SEQ_SHL: w_state_nxt = S_SHF;
                        SEQ_SHR: w_state_nxt = S_SHF;
                        default: w_state_nxt = S_DONE;
                    endcase
                end
            end

            S_ADD0: begin
                w_alu_op    = ALU_ADD;
                alu_op1     = w_a_byte;
                alu_op2     = w_b_byte;
                w_byte_we   = 1'b1;
                w_cflag_we  = 1'b1;
                w_cflag_dat = (alu_result < w_a_byte);
                w_idx_step  = 1'b1;
                w_state_nxt = S_ADC;
            end

            S_ADC: begin
                w_alu_op = ALU_ADC;
                alu_op1  = w_b_byte;
                w_t_we   = 1'b1;
                // b[i]+carry wrapped to zero: the byte sum is a[i] itself and carry stays set.
                if (alu_result < w_b_byte) begin
                    w_byte_we   = 1'b1;
                    w_byte_dat  = w_a_byte;
                    w_cflag_we  = 1'b1;
                    w_cflag_dat = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_step  = 1'b1;
                        w_state_nxt = S_ADC;
                    end
                end else begin
                    w_state_nxt = S_ADDH;
                end
            end

            S_ADDH: begin
                w_alu_op    = ALU_ADD;
                alu_op1     = w_a_byte;
                alu_op2     = r_t;
                w_byte_we   = 1'b1;
                w_cflag_we  = 1'b1;
                w_cflag_dat = (alu_result < w_a_byte);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_step  = 1'b1;
                    w_state_nxt = S_ADC;
                end
            end

            S_SHF: begin
                w_alu_op    = (r_op == SEQ_SHR) ? ALU_RSH : ALU_LSH;
                alu_op1     = w_a_byte;
                alu_op2     = {5'b00000, r_b[2:0]};
                w_byte_we   = 1'b1;
                w_idx_step  = 1'b1;
                w_state_nxt = S_SHO;
            end

            S_SHO: begin
                w_alu_op  = ALU_SHO;
                alu_op1   = w_a_byte;
                w_byte_we = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_step = 1'b1;
                end
            end

            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign alu_operation = w_alu_op;
    assign rsp_data      = r_res;
    assign rsp_carry     = r_cflag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_op    <= SEQ_ADD;
            r_idx   <= '0;
            r_t     <= 8'h00;
            r_cflag <= 1'b0;
        end else if (w_accept) begin
            r_a     <= req_a;
            r_b     <= req_b;
            r_op    <= seq_op_e'(req_op);
            r_idx   <= (seq_op_e'(req_op) == SEQ_SHR) ? LAST_IDX : '0;
            r_res   <= (seq_op_e'(req_op) == SEQ_RSV) ? req_a : '0;
            r_cflag <= 1'b0;
        end else begin
            if (w_byte_we) begin
                r_res[{r_idx, 3'b000} +: 8] <= w_byte_dat;
            end
            if (w_cflag_we) begin
                r_cflag <= w_cflag_dat;
            end
            if (w_t_we) begin
                r_t <= alu_result;
            end
            if (w_idx_step) begin
                r_idx <= w_idx_nxt;
            end
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] r_perf_ops;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_ops <= 16'h0000;
        end else if ((w_alu_op != ALU_NOP) && (r_perf_ops != 16'hFFFF)) begin
            r_perf_ops <= r_perf_ops + 16'd1;
        end
    end

    assign perf_ops = r_perf_ops;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomised and directed bench for alu_seq_ctrl with a behavioural ALU and a wide-arithmetic reference.
// Build with ALU_SEQ_PERF_EN defined to also check perf_ops.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_op = 2'd0;
    logic [W-1:0]   req_a = '0;
    logic [W-1:0]   req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_data;
    logic           rsp_carry;
    logic [7:0]     alu_op1;
    logic [7:0]     alu_op2;
    logic [3:0]     alu_operation;
    logic [7:0]     alu_result;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0]    perf_ops;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.NBYTES(NB)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_carry     (rsp_carry),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_operation (alu_operation),
        .alu_result    (alu_result)
`ifdef ALU_SEQ_PERF_EN
        ,
        .perf_ops      (perf_ops)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural 8-bit ALU: carry for ADD/ADC, spill register for LSH/RSH/SHO.
    logic       alu_c = 1'b0;
    logic [7:0] alu_spill = 8'h00;
    logic [2:0] alu_amt = 3'd0;
    logic       alu_dir = 1'b0;

    function automatic logic [7:0] spill_l(input logic [7:0] v, input logic [2:0] s);
        logic [15:0] t;
        t = {8'h00, v} << s;
        return t[15:8];
    endfunction

    function automatic logic [7:0] spill_r(input logic [7:0] v, input logic [2:0] s);
        logic [15:0] t;
        t = {v, 8'h00} >> s;
        return t[7:0];
    endfunction

    always_comb begin
        alu_result = 8'h00;
        case (alu_operation)
            4'd0:  alu_result = alu_op1 + alu_op2;
            4'd11: alu_result = alu_op1 + {7'b0, alu_c};
            4'd2:  alu_result = alu_op1 << alu_op2[2:0];
            4'd1:  alu_result = alu_op1 >> alu_op2[2:0];
            4'd10: alu_result = alu_dir ? ((alu_op1 >> alu_amt) | alu_spill)
                                        : ((alu_op1 << alu_amt) | alu_spill);
            default: alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        case (alu_operation)
            4'd0:  alu_c <= ({1'b0, alu_op1} + {1'b0, alu_op2}) > 9'd255;
            4'd11: alu_c <= ({1'b0, alu_op1} + {8'h00, alu_c}) > 9'd255;
            4'd2: begin
                alu_amt   <= alu_op2[2:0];
                alu_dir   <= 1'b0;
                alu_spill <= spill_l(alu_op1, alu_op2[2:0]);
            end
            4'd1: begin
                alu_amt   <= alu_op2[2:0];
                alu_dir   <= 1'b1;
                alu_spill <= spill_r(alu_op1, alu_op2[2:0]);
            end
            4'd10: alu_spill <= alu_dir ? spill_r(alu_op1, alu_amt) : spill_l(alu_op1, alu_amt);
            default: ;
        endcase
    end

    // Reference: wide arithmetic on the whole operand, plus op count from per-byte carry-in.
    task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] d, output logic c, output int ops);
        logic [63:0] m;
        logic [63:0] cin;
        logic [7:0]  bi;
        c   = 1'b0;
        ops = 0;
        case (op)
            2'd0: begin
                {c, d} = {1'b0, a} + {1'b0, b};
                ops = 1;
                for (int i = 1; i < NB; i++) begin
                    m   = (64'd1 << (8 * i)) - 64'd1;
                    cin = (({32'd0, a} & m) + ({32'd0, b} & m)) >> (8 * i);
                    bi  = 8'((b >> (8 * i)) & 32'hFF);
                    ops += ((bi == 8'hFF) && (cin != 0)) ? 1 : 2;
                end
            end
            2'd1: begin d = a << b[2:0]; ops = NB; end
            2'd2: begin d = a >> b[2:0]; ops = NB; end
            default: d = a;
        endcase
    endtask

    task automatic run_txn(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_d;
        logic         exp_c;
        int           exp_ops;
        int           lat;
        int           ops;
        bit           done;
`ifdef ALU_SEQ_PERF_EN
        logic [15:0]  p0;
`endif
        ref_model(op, a, b, exp_d, exp_c, exp_ops);
        @(negedge clk);
        check_val({tag, "_rdy"}, 64'(req_ready), 64'd1);
`ifdef ALU_SEQ_PERF_EN
        p0 = perf_ops;
`endif
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        req_op    = 2'($urandom);
        lat  = 1;
        ops  = 0;
        done = 1'b0;
        while (!done && lat < 64) begin
            @(negedge clk);
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (alu_operation != 4'd13) ops++;
                @(posedge clk);
                lat++;
            end
        end
        check_val({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check_val({tag, "_lat"}, 64'(lat), 64'(exp_ops + 1));
        check_val({tag, "_ops"}, 64'(ops), 64'(exp_ops));
        check_val({tag, "_data"}, 64'(rsp_data), 64'(exp_d));
        check_val({tag, "_carry"}, 64'(rsp_carry), 64'(exp_c));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val({tag, "_hold_data"}, 64'(rsp_data), 64'(exp_d));
            check_val({tag, "_hold_rdy"}, 64'(req_ready), 64'd0);
            check_val({tag, "_hold_aluop"}, 64'(alu_operation), 64'd13);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_val({tag, "_idle_rdy"}, 64'(req_ready), 64'd1);
        check_val({tag, "_idle_vld"}, 64'(rsp_valid), 64'd0);
`ifdef ALU_SEQ_PERF_EN
        check_val({tag, "_perf"}, 64'(perf_ops - p0), 64'(exp_ops));
`endif
    endtask

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_val("rst_rsp_carry", 64'(rsp_carry), 64'd0);
        check_val("rst_alu_op1", 64'(alu_op1), 64'd0);
        check_val("rst_alu_op2", 64'(alu_op2), 64'd0);
        check_val("rst_alu_operation", 64'(alu_operation), 64'd13);
`ifdef ALU_SEQ_PERF_EN
        check_val("rst_perf", 64'(perf_ops), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_txn("add_ff_1",   2'd0, 32'h000000FF, 32'h00000001, 0);
        run_txn("add_wrap",   2'd0, 32'h00000001, 32'hFFFFFFFF, 0);
        run_txn("shl4",       2'd1, 32'h12345678, 32'h00000004, 0);
        run_txn("shr4",       2'd2, 32'h12345678, 32'h00000004, 0);
        run_txn("shl0",       2'd1, 32'h12345678, 32'h00000000, 0);
        run_txn("shr0_bp",    2'd2, 32'h12345678, 32'hFFFFFFF8, 3);
        run_txn("rsv",        2'd3, 32'hDEADBEEF, 32'h12345678, 2);

        // Reset two ALU ops into an ADD: controller must drop to idle within the same cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_a     = 32'h89ABCDEF;
        req_b     = 32'h01020304;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_aluop", 64'(alu_operation), 64'd13);
        check_val("midrst_vld", 64'(rsp_valid), 64'd0);
        check_val("midrst_rdy", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        run_txn("add_after_rst", 2'd0, 32'h0000FFFF, 32'h00000001, 0);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            b  = W'($urandom);
            for (int k = 0; k < NB; k++) begin
                if ($urandom_range(0, 2) == 0) b[8*k +: 8] = 8'hFF;
                if ($urandom_range(0, 3) == 0) a[8*k +: 8] = 8'hFF;
            end
            run_txn($sformatf("rnd%0d", n), op, a, b, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
